pdm_record_ctrl: RTL and testbench

PDM_RECORD_CTRL -- requirements
Module: pdm_record_ctrl

---
 rtl/pdm_rec_pkg.sv | 16 +
 rtl/pdm_clk_div.sv | 46 ++++
 rtl/pdm_record_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pdm_record_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pdm_rec_pkg.sv
// pdm_rec_pkg
// Shared definitions for the PDM record/playback controller: controller
// state encoding (also the encoding seen on state_o), sample width and
// the default microphone clock divider.
package pdm_rec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    localparam int SAMPLE_W    = 16;
    localparam int CLK_DIV_DEF = 50;

endpackage

// File: rtl/pdm_clk_div.sv
// pdm_clk_div
// Generates the PDM microphone clock from the system clock while enabled.
// The counter runs 0..CLK_DIV-1 and the clock toggles on the terminal count,
// so one microphone clock period is 2*CLK_DIV system cycles.
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   enable     - run the divider; when low, counter/strobe/rise held at 0
//   strobe     - divided clock (pdm_clk)
//   rise       - high for the single cycle in which strobe is newly 1
module pdm_clk_div
    import pdm_rec_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic strobe,
    output logic rise
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            strobe <= 1'b0;
            rise   <= 1'b0;
        end else if (!enable) begin
            cnt    <= '0;
            strobe <= 1'b0;
            rise   <= 1'b0;
        end else if (cnt == CW'(CLK_DIV - 1)) begin
            cnt    <= '0;
            strobe <= ~strobe;
            // registered with the toggle so rise lines up with the 0->1 edge
            rise   <= ~strobe;
        end else begin
            cnt    <= cnt + CW'(1);
            rise   <= 1'b0;
        end
    end

endmodule

// File: rtl/pdm_record_ctrl.sv
// pdm_record_ctrl
// Records 16-bit words from a PDM deserializer into a sample memory and
// plays them back at a fixed sample rate.
// Ports:
//   clock_i, reset_ni           - clock, asynchronous active-low reset
//   record_i, play_i, stop_i    - command pulses (stop > record > play)
//   pdm_clk_o, pdm_lrsel_o      - microphone clock and channel select (0)
//   des_enable_o                - deserializer strobe on pdm_clk_o rise
//   des_done_i, des_data_i      - deserializer word-done and word
//   mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_rdata_i    - sample memory (read latency 1 cycle)
//   sample_o, sample_valid_o    - playback sample and strobe
//   state_o, full_o             - controller state, memory filled
// Build option: PDM_LOOP_EN makes playback loop until stop_i instead of
// returning to IDLE after the last recorded word.
//
// state     | meaning
// ST_IDLE   | waiting for record_i / play_i
// ST_RECORD | divider running, deserialized words written to memory
// ST_PLAY   | reading one word every 32*CLK_DIV cycles
module pdm_record_ctrl
    import pdm_rec_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int ADDR_W  = 10
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic                record_i,
    input  logic                play_i,
    input  logic                stop_i,
    output logic                pdm_clk_o,
    output logic                pdm_lrsel_o,
    output logic                des_enable_o,
    input  logic                des_done_i,
    input  logic [SAMPLE_W-1:0] des_data_i,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [SAMPLE_W-1:0] mem_wdata_o,
    input  logic [SAMPLE_W-1:0] mem_rdata_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sample_valid_o,
    output logic [1:0]          state_o,
    output logic                full_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TICK  = 32 * CLK_DIV;
    localparam int TW    = $clog2(TICK + 1);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   waddr, waddr_nx;
    logic [ADDR_W-1:0]   raddr, raddr_nx;
    logic [ADDR_W:0]     rec_len, rec_len_nx;
    logic                full, full_nx;
    logic [TW-1:0]       tcnt, tcnt_nx;
    logic                rd_pend, rd_pend_nx;
    logic                last_rd, last_rd_nx;
    logic [SAMPLE_W-1:0] sample_q, sample_nx;
    logic                at_end;

    pdm_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk    (clock_i),
        .rst_n  (reset_ni),
        .enable (state == ST_RECORD),
        .strobe (pdm_clk_o),
        .rise   (des_enable_o)
    );

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= ST_IDLE;
            waddr    <= '0;
            raddr    <= '0;
            rec_len  <= '0;
            full     <= 1'b0;
            tcnt     <= '0;
            rd_pend  <= 1'b0;
            last_rd  <= 1'b0;
            sample_q <= '0;
        end else begin
            state    <= state_nx;
            waddr    <= waddr_nx;
            raddr    <= raddr_nx;
            rec_len  <= rec_len_nx;
            full     <= full_nx;
            tcnt     <= tcnt_nx;
            rd_pend  <= rd_pend_nx;
            last_rd  <= last_rd_nx;
            sample_q <= sample_nx;
        end
    end

    assign at_end = ({1'b0, raddr} == rec_len - (ADDR_W + 1)'(1));

    always_comb begin
        state_nx    = state;
        waddr_nx    = waddr;
        raddr_nx    = raddr;
        rec_len_nx  = rec_len;
        full_nx     = full;
        tcnt_nx     = tcnt;
        rd_pend_nx  = 1'b0;
        last_rd_nx  = last_rd;
        sample_nx   = sample_q;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state)
            ST_IDLE: begin
                if (!stop_i) begin
                    if (record_i) begin
                        state_nx   = ST_RECORD;
                        waddr_nx   = '0;
                        full_nx    = 1'b0;
                        rec_len_nx = '0;
                    end else if (play_i && rec_len != '0) begin
                        state_nx = ST_PLAY;
                        raddr_nx = '0;
                        tcnt_nx  = TW'(TICK);
                    end
                end
            end
            ST_RECORD: begin
                mem_addr_o = waddr;
                if (stop_i) begin
                    // waddr equals the number of words written so far
                    state_nx   = ST_IDLE;
                    rec_len_nx = {1'b0, waddr};
                end else if (des_done_i) begin
                    mem_we_o    = 1'b1;
                    mem_wdata_o = des_data_i;
                    if (&waddr) begin
                        full_nx    = 1'b1;
                        rec_len_nx = (ADDR_W + 1)'(DEPTH);
                        state_nx   = ST_IDLE;
                    end else begin
                        waddr_nx = waddr + ADDR_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                mem_addr_o = raddr;
                if (rd_pend) begin
                    sample_nx = mem_rdata_i;
                end
                if (stop_i) begin
                    state_nx = ST_IDLE;
                end else begin
`ifndef PDM_LOOP_EN
                    if (rd_pend && last_rd) begin
                        state_nx = ST_IDLE;
                    end
`endif
                    if (tcnt == '0) begin
                        tcnt_nx    = TW'(TICK - 1);
                        rd_pend_nx = 1'b1;
                        last_rd_nx = at_end;
`ifdef PDM_LOOP_EN
                        raddr_nx   = at_end ? '0 : raddr + ADDR_W'(1);
`else
                        raddr_nx   = raddr + ADDR_W'(1);
`endif
                    end else begin
                        tcnt_nx = tcnt - TW'(1);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Read data arrives the cycle after the tick; it is shown directly and
    // captured so sample_o holds between strobes.
    assign sample_o       = rd_pend ? mem_rdata_i : sample_q;
    assign sample_valid_o = rd_pend;
    assign state_o        = state;
    assign full_o         = full;
    assign pdm_lrsel_o    = 1'b0;

endmodule

// File: tb/tb_pdm_record_ctrl.sv
module tb_pdm_record_ctrl;

    localparam int CLK_DIV = 2;
    localparam int ADDR_W  = 3;
    localparam int TICK    = 64;   // 32*CLK_DIV

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        record = 1'b0, play = 1'b0, stop = 1'b0;
    logic        pdm_clk, lrsel, des_en;
    logic        des_done = 1'b0;
    logic [15:0] des_data = '0;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [15:0] sample;
    logic        sample_valid;
    logic [1:0]  state;
    logic        full;

    pdm_record_ctrl #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
        .clock_i        (clk),
        .reset_ni       (rst_n),
        .record_i       (record),
        .play_i         (play),
        .stop_i         (stop),
        .pdm_clk_o      (pdm_clk),
        .pdm_lrsel_o    (lrsel),
        .des_enable_o   (des_en),
        .des_done_i     (des_done),
        .des_data_i     (des_data),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .sample_o       (sample),
        .sample_valid_o (sample_valid),
        .state_o        (state),
        .full_o         (full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // sample memory with one-cycle read latency
    logic [15:0] mem [8];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int pass_cnt = 0, total_cnt = 0;
    int nvalid = 0;
    int next_valid_cyc = 0;
    logic [31:0] wq[$];
    logic [15:0] sq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // monitor: pops scoreboard entries whenever the DUT presents a write or sample
    always @(negedge clk) begin
        if (mem_we) begin
            if (wq.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: addr %0d data %0h (cycle %0d)", mem_addr, mem_wdata, cyc);
            end else begin
                chk("write", {13'd0, mem_addr, mem_wdata}, wq.pop_front());
            end
        end
        if (sample_valid) begin
            if (sq.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_sample: data %0h (cycle %0d)", sample, cyc);
            end else begin
                chk("sample", {16'd0, sample}, {16'd0, sq.pop_front()});
                chk("sample_time", 32'(cyc), 32'(next_valid_cyc));
                next_valid_cyc += TICK;
            end
            nvalid++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [15:0] d, input logic [2:0] a);
        des_done = 1'b1;
        des_data = d;
        wq.push_back({13'd0, a, d});
        step();
        des_done = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_pdm"}, 32'({pdm_clk, lrsel, des_en, mem_we, sample_valid, full}), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_sample"}, 32'(sample), 0);
    endtask

    logic [15:0] dv [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    logic [15:0] fv [8] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                            16'hA004, 16'hA005, 16'hA006, 16'hA007};

    initial begin
        int c, n_exp;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // play with nothing recorded: stays IDLE, address untouched
        play = 1'b1; step(); play = 1'b0;
        repeat (3) begin
            step();
            chk("empty_play_state", 32'(state), 0);
            chk("empty_play_addr", 32'(mem_addr), 0);
        end

        // record: divider pattern, pdm_clk period 4, des_enable on each rise
        c = cyc;
        record = 1'b1; step(); record = 1'b0;
        chk("rec_state", 32'(state), 1);
        for (int k = 1; k <= 16; k++) begin
            chk("pdm_clk", 32'(pdm_clk), 32'((k >= 3) && (((k - 3) / 2) % 2 == 0)));
            chk("des_enable", 32'(des_en), 32'((k >= 3) && ((k - 3) % 4 == 0)));
            step();
        end
        if (cyc != c + 17) chk("div_window", 32'(cyc), 32'(c + 17));

        // five words; a record_i mid-recording must be ignored
        for (int i = 0; i < 5; i++) begin
            word(dv[i], 3'(i));
            if (i == 1) begin record = 1'b1; step(); record = 1'b0; end
            repeat (6) step();
        end
        // stop together with des_done: that word is dropped
        stop = 1'b1; des_done = 1'b1; des_data = 16'hDEAD;
        step();
        stop = 1'b0; des_done = 1'b0;
        chk("stop_rec_state", 32'(state), 0);
        chk("stop_rec_full", 32'(full), 0);

        // playback of the five words
`ifdef PDM_LOOP_EN
        n_exp = 7;
`else
        n_exp = 5;
`endif
        for (int i = 0; i < n_exp; i++) sq.push_back(dv[i % 5]);
        nvalid = 0;
        next_valid_cyc = cyc + TICK + 2;
        play = 1'b1; step(); play = 1'b0;
        chk("play_state", 32'(state), 2);
        for (int t = 0; t < 10 * TICK && nvalid < n_exp; t++) step();
        chk("play_count", 32'(nvalid), 32'(n_exp));
`ifdef PDM_LOOP_EN
        chk("loop_still_play", 32'(state), 2);
        stop = 1'b1; record = 1'b1; step(); stop = 1'b0; record = 1'b0;
`endif
        chk("play_end_state", 32'(state), 0);
        chk("play_queue_left", 32'(sq.size()), 0);
        repeat (2 * TICK) step();

        // fill all eight addresses, des_done every 8 cycles
        record = 1'b1; step(); record = 1'b0; step();
        for (int i = 0; i < 8; i++) begin
            word(fv[i], 3'(i));
            if (i < 7) repeat (7) step();
        end
        chk("full_state", 32'(state), 0);
        chk("full_flag", 32'(full), 1);
        des_done = 1'b1; des_data = 16'hBEEF; step(); des_done = 1'b0;
        chk("idle_done_state", 32'(state), 0);

        // stop and record together in PLAY: end in IDLE, recording kept
        play = 1'b1; step(); play = 1'b0;
        repeat (20) step();
        stop = 1'b1; record = 1'b1; step(); stop = 1'b0; record = 1'b0;
        chk("stop_rec_in_play_state", 32'(state), 0);
        chk("stop_rec_in_play_full", 32'(full), 1);
        repeat (2 * TICK) step();

        // reset mid-PLAY after the first sample
        sq.push_back(fv[0]);
        nvalid = 0;
        next_valid_cyc = cyc + TICK + 2;
        play = 1'b1; step(); play = 1'b0;
        repeat (TICK + 10) step();
        chk("mid_play_samples", 32'(nvalid), 1);
        chk("mid_play_state", 32'(state), 2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        repeat (2) step();
        rst_n = 1'b1;
        step();
        play = 1'b1; step(); play = 1'b0;
        repeat (4) step();
        chk_all_zero("post_reset_play");
        repeat (2 * TICK) step();
        chk("post_reset_no_sample", 32'(nvalid), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
